// File: rtl/ycr_arb_pkg.sv
// Shared encodings for the 2-way arbiter and its response router.
package ycr_arb_pkg;

   localparam logic [1:0] GNT_M0   = 2'b00;
   localparam logic [1:0] GNT_M1   = 2'b01;
   localparam logic [1:0] GNT_NONE = 2'b11;

   typedef logic tag_t;

   localparam tag_t TAG_M0 = 1'b0;
   localparam tag_t TAG_M1 = 1'b1;

   localparam logic CMD_RD = 1'b0;
   localparam logic CMD_WR = 1'b1;

endpackage

// File: rtl/ycr_tag_fifo.sv
// In-order FIFO of master ids, one entry per outstanding shared-port request.
module ycr_tag_fifo
   import ycr_arb_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push_i,
   input  logic          push_tag_i,
   input  logic          pop_i,
   output logic          head_tag_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   tag_t          mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full_o     = (count_q == CW'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign head_tag_o = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; an entry is only read while count says it is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
   end

endmodule

// File: rtl/ycr_arb2_resp_router.sv
// Forwards the granted master onto the shared port and steers in-order responses back.
module ycr_arb2_resp_router
   import ycr_arb_pkg::*;
#(
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int OUTSTD = 2
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [1:0]    gnt,
   output logic          ack,
   input  logic          m0_req,
   input  logic          m0_cmd,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_req_ack,
   output logic          m0_resp,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_cmd,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_req_ack,
   output logic          m1_resp,
   output logic [DW-1:0] m1_rdata,
   output logic          s_req,
   output logic          s_cmd,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_wdata,
   input  logic          s_req_ack,
   input  logic          s_resp,
   input  logic [DW-1:0] s_rdata,
   output logic          err_stray
);

   localparam int CW = $clog2(OUTSTD) + 1;
   localparam logic [CW-1:0] MAX_CNT = CW'(OUTSTD);

   tag_t          sel, head_tag;
   logic          gnt_valid, sel_req, acc, pop, stray;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;

   logic          m0_resp_q, m0_resp_d, m1_resp_q, m1_resp_d;
   logic [DW-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
   logic          err_stray_q, err_stray_d;

   // 2'b10 is not a legal grant and is treated exactly like GNT_NONE.
   assign gnt_valid = (gnt == GNT_M0) || (gnt == GNT_M1);
   assign sel       = gnt[0];
   assign sel_req   = (sel == TAG_M1) ? m1_req : m0_req;

   assign s_req   = gnt_valid & sel_req & ~fifo_full;
   assign s_cmd   = gnt_valid ? ((sel == TAG_M1) ? m1_cmd   : m0_cmd)   : CMD_RD;
   assign s_addr  = gnt_valid ? ((sel == TAG_M1) ? m1_addr  : m0_addr)  : '0;
   assign s_wdata = gnt_valid ? ((sel == TAG_M1) ? m1_wdata : m0_wdata) : '0;

   assign acc        = s_req & s_req_ack;
   assign ack        = acc;
   assign m0_req_ack = acc & (sel == TAG_M0);
   assign m1_req_ack = acc & (sel == TAG_M1);

   assign pop   = s_resp & ~fifo_empty;
   assign stray = s_resp & fifo_empty;

   ycr_tag_fifo #(.DEPTH(OUTSTD)) u_tag_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .push_i     (acc),
      .push_tag_i (sel),
      .pop_i      (pop),
      .head_tag_o (head_tag),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      m0_resp_d   = 1'b0;
      m1_resp_d   = 1'b0;
      m0_rdata_d  = m0_rdata_q;
      m1_rdata_d  = m1_rdata_q;
      err_stray_d = err_stray_q | stray;
      if (pop) begin
         if (head_tag == TAG_M1) begin
            m1_resp_d  = 1'b1;
            m1_rdata_d = s_rdata;
         end else begin
            m0_resp_d  = 1'b1;
            m0_rdata_d = s_rdata;
         end
      end
   end

   // NOTE: non-blocking assignments keep every register update on the same clock edge.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         m0_resp_q   <= 1'b0;
         m1_resp_q   <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
         err_stray_q <= 1'b0;
      end else begin
         m0_resp_q   <= m0_resp_d;
         m1_resp_q   <= m1_resp_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
         err_stray_q <= err_stray_d;
      end
   end

   assign m0_resp   = m0_resp_q;
   assign m1_resp   = m1_resp_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;
   assign err_stray = err_stray_q;

   a_count_bounded : assert property (@(posedge clk) disable iff (!rstn) fifo_count <= MAX_CNT);

endmodule

// File: tb/tb_ycr_arb2_resp_router.sv
// Scoreboard bench: expected responses are queued when s_resp is driven and checked when they appear.
module tb_ycr_arb2_resp_router;
   import ycr_arb_pkg::*;

   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int OUTSTD = 2;

   logic          clk = 1'b0;
   logic          rstn;
   logic [1:0]    gnt;
   logic          ack;
   logic          m0_req, m0_cmd, m0_req_ack, m0_resp;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic          m1_req, m1_cmd, m1_req_ack, m1_resp;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic          s_req, s_cmd, s_req_ack, s_resp;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata, s_rdata;
   logic          err_stray;

   int n_checks = 0;
   int n_errors = 0;
   bit mon_en   = 1'b0;

   bit            tagq [$];
   logic [DW:0]   exp_q [$];
   logic [DW-1:0] exp_rdata [2];
   bit            exp_stray;

   always #5 clk = ~clk;

   ycr_arb2_resp_router #(.AW(AW), .DW(DW), .OUTSTD(OUTSTD)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .gnt        (gnt),
      .ack        (ack),
      .m0_req     (m0_req),
      .m0_cmd     (m0_cmd),
      .m0_addr    (m0_addr),
      .m0_wdata   (m0_wdata),
      .m0_req_ack (m0_req_ack),
      .m0_resp    (m0_resp),
      .m0_rdata   (m0_rdata),
      .m1_req     (m1_req),
      .m1_cmd     (m1_cmd),
      .m1_addr    (m1_addr),
      .m1_wdata   (m1_wdata),
      .m1_req_ack (m1_req_ack),
      .m1_resp    (m1_resp),
      .m1_rdata   (m1_rdata),
      .s_req      (s_req),
      .s_cmd      (s_cmd),
      .s_addr     (s_addr),
      .s_wdata    (s_wdata),
      .s_req_ack  (s_req_ack),
      .s_resp     (s_resp),
      .s_rdata    (s_rdata),
      .err_stray  (err_stray)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic idle_inputs();
      gnt = GNT_NONE;
      m0_req = 1'b0; m0_cmd = CMD_RD; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_cmd = CMD_RD; m1_addr = '0; m1_wdata = '0;
      s_req_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
   endtask

   // Checks the combinational request path against the model, then advances one clock.
   task automatic step(input string tag);
      bit            gv, sel, mreq, full, e_sreq, e_acc, t;
      logic [AW-1:0] ea;
      logic [DW-1:0] ew;
      logic          ec;
      #1;
      gv     = (gnt == 2'b00) || (gnt == 2'b01);
      sel    = gnt[0];
      mreq   = sel ? m1_req : m0_req;
      full   = (tagq.size() == OUTSTD);
      e_sreq = gv && mreq && !full;
      e_acc  = e_sreq && s_req_ack;
      ea     = gv ? (sel ? m1_addr  : m0_addr)  : '0;
      ew     = gv ? (sel ? m1_wdata : m0_wdata) : '0;
      ec     = gv ? (sel ? m1_cmd   : m0_cmd)   : 1'b0;
      check({tag, ".s_req"},      64'(s_req),      64'(e_sreq));
      check({tag, ".ack"},        64'(ack),        64'(e_acc));
      check({tag, ".m0_req_ack"}, 64'(m0_req_ack), 64'(e_acc && !sel));
      check({tag, ".m1_req_ack"}, 64'(m1_req_ack), 64'(e_acc && sel));
      check({tag, ".s_addr"},     64'(s_addr),     64'(ea));
      check({tag, ".s_wdata"},    64'(s_wdata),    64'(ew));
      check({tag, ".s_cmd"},      64'(s_cmd),      64'(ec));
      @(posedge clk);
      if (!rstn) begin
         tagq.delete();
         exp_q.delete();
         exp_stray    = 1'b0;
         exp_rdata[0] = '0;
         exp_rdata[1] = '0;
      end else begin
         if (s_resp) begin
            if (tagq.size() > 0) begin
               t = tagq.pop_front();
               exp_q.push_back({t, s_rdata});
            end else begin
               exp_stray = 1'b1;
            end
         end
         if (e_acc) tagq.push_back(sel);
      end
      @(negedge clk);
   endtask

   // Registered response outputs, checked every cycle on the falling edge.
   always @(negedge clk) begin
      logic [DW:0] e;
      bit e0, e1;
      if (mon_en) begin
         e0 = 1'b0;
         e1 = 1'b0;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[DW]) begin e1 = 1'b1; exp_rdata[1] = e[DW-1:0]; end
            else       begin e0 = 1'b1; exp_rdata[0] = e[DW-1:0]; end
         end
         check("m0_resp",   64'(m0_resp),   64'(e0));
         check("m1_resp",   64'(m1_resp),   64'(e1));
         check("m0_rdata",  64'(m0_rdata),  64'(exp_rdata[0]));
         check("m1_rdata",  64'(m1_rdata),  64'(exp_rdata[1]));
         check("err_stray", 64'(err_stray), 64'(exp_stray));
      end
   end

   initial begin
      idle_inputs();
      rstn = 1'b0;
      exp_stray = 1'b0;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      step("rst0");
      step("rst1");
      mon_en = 1'b1;
      rstn = 1'b1;

      // Single read from master0
      gnt = GNT_M0; m0_req = 1'b1; m0_addr = 32'h100; s_req_ack = 1'b1;
      step("t1_req");
      idle_inputs(); s_resp = 1'b1; s_rdata = 32'hA5A5_A5A5;
      step("t1_resp");
      idle_inputs();
      step("t1_idle");

      // Interleaved m0 write then m1 read, in-order responses
      gnt = GNT_M0; m0_req = 1'b1; m0_cmd = CMD_WR; m0_addr = 32'h104; m0_wdata = 32'hDEAD_BEEF;
      s_req_ack = 1'b1;
      step("il_m0");
      gnt = GNT_M1; m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h200;
      step("il_m1");
      idle_inputs(); s_resp = 1'b1; s_rdata = 32'h11;
      step("il_r0");
      s_rdata = 32'h22;
      step("il_r1");
      idle_inputs();
      step("il_idle");

      // Fill to OUTSTD, blocked request, then push+pop at count=1
      gnt = GNT_M0; m0_req = 1'b1; m0_addr = 32'h300; s_req_ack = 1'b1;
      step("full_a");
      gnt = GNT_M1; m1_req = 1'b1; m1_addr = 32'h400;
      step("full_b");
      gnt = GNT_M0; m0_addr = 32'h500;
      step("full_blk");
      s_resp = 1'b1; s_rdata = 32'h33;
      step("full_blk_resp");
      s_rdata = 32'h44;
      step("pp_cnt1");
      idle_inputs(); s_resp = 1'b1; s_rdata = 32'h55;
      step("pp_drain");
      idle_inputs();
      step("pp_idle");

      // Stray response: sticky until reset
      s_resp = 1'b1; s_rdata = 32'hBAD;
      step("stray");
      idle_inputs();
      step("stray_hold0");
      step("stray_hold1");
      rstn = 1'b0;
      step("stray_rst");
      rstn = 1'b1;
      step("post_rst");

      // No-grant encodings with both masters requesting
      gnt = GNT_NONE; m0_req = 1'b1; m1_req = 1'b1; s_req_ack = 1'b1;
      m0_addr = 32'hAAAA; m1_addr = 32'hBBBB; m0_wdata = 32'h1; m1_wdata = 32'h2;
      step("gnt11");
      gnt = 2'b10;
      step("gnt10");

      // Push and pop together while empty: pop is stray, push kept
      idle_inputs();
      gnt = GNT_M1; m1_req = 1'b1; m1_addr = 32'h600; s_req_ack = 1'b1;
      s_resp = 1'b1; s_rdata = 32'h77;
      step("pp_cnt0");
      idle_inputs(); s_resp = 1'b1; s_rdata = 32'h66;
      step("pp_cnt0_drain");
      idle_inputs();
      step("pp_cnt0_idle");

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0: gnt = GNT_M0;
            1: gnt = GNT_M1;
            2: gnt = GNT_NONE;
            default: gnt = 2'b10;
         endcase
         m0_req = 1'($urandom); m0_cmd = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
         m1_req = 1'($urandom); m1_cmd = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
         s_req_ack = ($urandom_range(0, 3) != 0);
         s_resp = ($urandom_range(0, 9) < 4);
         s_rdata = $urandom;
         step("rnd");
      end

      // Drain whatever is still outstanding
      idle_inputs();
      for (int i = 0; i < OUTSTD + 2; i++) begin
         if (tagq.size() > 0) begin
            s_resp = 1'b1; s_rdata = $urandom;
         end else begin
            s_resp = 1'b0;
         end
         step("drain");
      end
      idle_inputs();
      step("final_idle");
      check("exp_q_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ycr_arb2_resp_router.md
Name: ycr_arb2_resp_router

Overview:
Downstream companion to the 2-way round-robin arbiter. It takes the arbiter's registered grant and forwards the granted master's request to the single shared memory port. It returns the one-cycle `ack` pulse that releases the arbiter from its wait state. It tracks outstanding transactions in an in-order tag FIFO, so each memory response is steered back to the master that issued it.

Parameters:
AW, 32, address width
DW, 32, data width
OUTSTD, 2, max outstanding requests (tag FIFO depth, power of 2, >=2)

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous and active-low
gnt  in  2  grant from arbiter: 2'b00 = master0, 2'b01 = master1, 2'b11 = none
ack  out  1  to arbiter; one-cycle pulse on each accepted request
m0_req  in  1  master0 request valid
m0_cmd  in  1  master0 command: 1 = write, 0 = read
m0_addr  in  AW  master0 address
m0_wdata  in  DW  master0 write data
m0_req_ack  out  1  master0 request accepted
m0_resp  out  1  master0 response valid
m0_rdata  out  DW  master0 read data
m1_req, m1_cmd, m1_addr, m1_wdata, m1_req_ack, m1_resp, m1_rdata  as for master0
s_req  out  1  shared port request valid
s_cmd  out  1  shared port command
s_addr  out  AW  shared port address
s_wdata  out  DW  shared port write data
s_req_ack  in  1  shared port accepted request
s_resp  in  1  shared port response valid (in order)
s_rdata  in  DW  shared port read data
err_stray  out  1  sticky flag: a response arrived with no outstanding tag

Behaviour:
- Reset (rstn=0 at a clk edge):
  - tag FIFO empty, count=0, pointers=0.
  - m0_resp, m1_resp, m0_rdata, m1_rdata, err_stray all 0.
  - Combinational outputs are also 0 while gnt=2'b11.
- Request path (combinational, 0 cycles):
  - sel = gnt[0]. valid_sel = (gnt != 2'b11) and m<sel>_req and !full.
  - s_req = valid_sel. s_cmd, s_addr, s_wdata = mux(sel); they are 0 when gnt=2'b11.
- Accept condition: acc = s_req & s_req_ack.
  - On acc: m<sel>_req_ack=1 and ack=1 in the same cycle, and sel is pushed into the tag FIFO at the clk edge.
- Grant values 2'b10 or 2'b11: treated as no grant. All m*_req_ack=0 and ack=0.
- Full: count==OUTSTD forces s_req=0. Masters stall and the arbiter stays in its wait state. There is no push/pop bypass when full.
- Response path (registered, 1 cycle):
  - On s_resp with count>0: pop the head tag. Next cycle, m<tag>_resp=1 and m<tag>_rdata=s_rdata for exactly one cycle. The other master's resp is 0 and its rdata holds its previous value.
- Stray response: s_resp with count==0. No pop, no m*_resp; err_stray<=1 and holds until reset.
- Simultaneous push and pop, count not full and not empty: both happen and count is unchanged.
- Simultaneous push and pop at count==0: the pop is stray (the pushed tag was not yet visible); the push is still applied.
- Pointers wrap modulo OUTSTD. Count is ceil(log2(OUTSTD))+1 bits wide and never exceeds OUTSTD.
- Reset mid-operation: outstanding tags are discarded. Responses arriving after reset are stray.

Decomposition:
- Shared package ycr_arb_pkg holds:
  - grant encodings GNT_M0=2'b00, GNT_M1=2'b01, GNT_NONE=2'b11
  - typedef tag_t (1-bit master id)
  - the command encoding constants
- Sub-module ycr_tag_fifo: synchronous FIFO, width 1, depth OUTSTD, with push/pop/full/empty/count outputs. It is instantiated once.

Test Plan:
- Reset, then gnt=2'b00, m0_req=1, addr=0x100, s_req_ack=1 -> s_req=1, s_addr=0x100, ack=1 and m0_req_ack=1 in the same cycle. s_resp with rdata=0xA5A5A5A5 one cycle later -> next cycle m0_resp=1, m0_rdata=0xA5A5A5A5, m1_resp=0.
- Interleave: accept m0 then m1, responses 0x11 then 0x22 -> m0 gets 0x11, then m1 gets 0x22, in order.
- OUTSTD=2 with two accepted requests and no response -> third request sees s_req=0 and ack=0. After one s_resp, s_req reasserts the next cycle.
- s_resp with FIFO empty -> err_stray=1 and sticky, no m*_resp. rstn=0 for one edge -> err_stray=0.
- gnt=2'b11 with m0_req=m1_req=1 -> s_req=0, ack=0, both req_ack=0.
- Push and pop in the same cycle at count=1 -> count stays 1, the correct master receives its response, and the new tag is preserved.
